// File: rtl/y_centroid.sv
// Bright-pixel centroid: accumulates count/sum_x/sum_y per frame, then runs two
// 32-step restoring dividers and reports the mean position once per frame.
module y_centroid #(
  parameter int H_ACTIVE  = 1280,
  parameter int V_ACTIVE  = 720,
  parameter int MIN_COUNT = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        valid_in,
  input  logic [7:0]  y_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [7:0]  threshold_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic        found_out,
  output logic        valid_out
);

  // state  | meaning
  // IDLE   | accumulating, waiting for frame end
  // DIVIDE | 32 restoring-division iterations in flight
  // DONE   | valid_out pulse, results registered
  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;

  localparam logic [11:0] H_LIM   = 12'(H_ACTIVE);
  localparam logic [10:0] V_LIM   = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [19:0] MIN_CNT = 20'(MIN_COUNT);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [31:0] sumx_q, sumx_d, sumy_q, sumy_d;
  logic [19:0] div_q, div_d;
  logic [31:0] quox_q, quox_d, quoy_q, quoy_d;
  logic [19:0] remx_q, remx_d, remy_q, remy_d;
  logic [4:0]  iter_q, iter_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        found_q, found_d;

  logic        in_range, bright, frame_end;
  logic [19:0] cnt_tot;
  logic [31:0] sumx_tot, sumy_tot;
  logic [20:0] remx_sh, remy_sh;
  logic        bitx, bity;
  logic [31:0] quox_nxt, quoy_nxt;
  logic [19:0] remx_nxt, remy_nxt;

  always_comb begin
    in_range  = ({1'b0, hcount_in} < H_LIM) && ({1'b0, vcount_in} < V_LIM);
    bright    = valid_in && in_range && (y_in >= threshold_in);
    frame_end = valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    cnt_tot   = cnt_q + {19'b0, bright};
    sumx_tot  = sumx_q + (bright ? {21'b0, hcount_in} : 32'b0);
    sumy_tot  = sumy_q + (bright ? {22'b0, vcount_in} : 32'b0);

    // one restoring step per divider: shift in next dividend bit, subtract if it fits
    remx_sh  = {remx_q, quox_q[31]};
    remy_sh  = {remy_q, quoy_q[31]};
    bitx     = remx_sh >= {1'b0, div_q};
    bity     = remy_sh >= {1'b0, div_q};
    remx_nxt = bitx ? 20'(remx_sh - {1'b0, div_q}) : remx_sh[19:0];
    remy_nxt = bity ? 20'(remy_sh - {1'b0, div_q}) : remy_sh[19:0];
    quox_nxt = {quox_q[30:0], bitx};
    quoy_nxt = {quoy_q[30:0], bity};
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    quox_d  = quox_q;
    quoy_d  = quoy_q;
    remx_d  = remx_q;
    remy_d  = remy_q;
    iter_d  = iter_q;
    x_d     = x_q;
    y_d     = y_q;
    found_d = found_q;

    // accumulators never stall; a frame end always restarts them
    cnt_d  = frame_end ? 20'b0 : cnt_tot;
    sumx_d = frame_end ? 32'b0 : sumx_tot;
    sumy_d = frame_end ? 32'b0 : sumy_tot;

    case (state_q)
      IDLE: begin
        if (frame_end) begin
          div_d  = cnt_tot;
          quox_d = sumx_tot;
          quoy_d = sumy_tot;
          remx_d = '0;
          remy_d = '0;
          iter_d = '0;
          if (cnt_tot >= MIN_CNT) begin
            state_d = DIVIDE;
          end else begin
            state_d = DONE;
            x_d     = '0;
            y_d     = '0;
            found_d = 1'b0;
          end
        end
      end
      DIVIDE: begin
        quox_d = quox_nxt;
        quoy_d = quoy_nxt;
        remx_d = remx_nxt;
        remy_d = remy_nxt;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = DONE;
          x_d     = quox_nxt[10:0];
          y_d     = quoy_nxt[9:0];
          found_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sumx_q  <= '0;
      sumy_q  <= '0;
      div_q   <= '0;
      quox_q  <= '0;
      quoy_q  <= '0;
      remx_q  <= '0;
      remy_q  <= '0;
      iter_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sumx_q  <= sumx_d;
      sumy_q  <= sumy_d;
      div_q   <= div_d;
      quox_q  <= quox_d;
      quoy_q  <= quoy_d;
      remx_q  <= remx_d;
      remy_q  <= remy_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      y_q     <= y_d;
      found_q <= found_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign found_out = found_q;
  assign valid_out = (state_q == DONE);

endmodule

// File: tb/tb_y_centroid.sv
// Scoreboarded bench for y_centroid on an 8x4 frame; expected results and
// their arrival cycles are queued by the driver and checked by a monitor.
module tb_y_centroid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  y_in = '0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [7:0]  threshold_in = 8'd128;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        found_out;
  logic        valid_out;

  y_centroid #(.H_ACTIVE(8), .V_ACTIVE(4), .MIN_COUNT(1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid_in), .y_in(y_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .threshold_in(threshold_in),
    .x_out(x_out), .y_out(y_out), .found_out(found_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int x; int y; int f; int c;} exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  int last_done = -1;
  logic [7:0] img [0:3][0:7];

  task automatic check(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got valid_out=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("x_out", int'(x_out), e.x);
        check("y_out", int'(y_out), e.y);
        check("found_out", int'(found_out), e.f);
        check("latency", cyc, e.c);
      end
    end
  end

  task automatic drive_pix(input int c, input int r, input logic [7:0] y, input logic v);
    valid_in  = v;
    hcount_in = 11'(c);
    vcount_in = 10'(r);
    y_in      = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_img(input logic [7:0] v);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  // streams one frame; queues a result only if the DUT will be IDLE at frame end
  task automatic send_frame(input int ex, input int ey, input int ef, input bit inject);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        if (inject && r == 1 && c == 4) begin
          drive_pix(9, 1, 8'd255, 1'b1);
          drive_pix(7, 3, 8'd255, 1'b0);
        end
        if (r == 3 && c == 7 && cyc > last_done) begin
          exp_t e;
          e.x = ex; e.y = ey; e.f = ef;
          e.c = (ef != 0) ? cyc + 33 : cyc + 1;
          exp_q.push_back(e);
          last_done = e.c;
        end
        drive_pix(c, r, img[r][c], 1'b1);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_found", int'(found_out), 0);
    check("rst_valid", int'(valid_out), 0);
    rst_n = 1'b1;
    idle(2);

    // single pixel at (5,2)
    fill_img(8'd0); img[2][5] = 8'd200;
    send_frame(5, 2, 1, 0);
    drain();

    // (2,1)+(5,3): floor(7/2)=3, y=2; result must hold afterwards
    fill_img(8'd0); img[1][2] = 8'd255; img[3][5] = 8'd255;
    send_frame(3, 2, 1, 0);
    drain();
    idle(10);
    check("hold_x", int'(x_out), 3);
    check("hold_y", int'(y_out), 2);
    check("hold_found", int'(found_out), 1);

    // nothing bright, then threshold equality at (0,0)
    fill_img(8'd127);
    send_frame(0, 0, 0, 0);
    img[0][0] = 8'd128;
    send_frame(0, 0, 1, 0);
    drain();

    // out-of-range pixel and invalid pixel must be ignored
    fill_img(8'd0); img[1][1] = 8'd255;
    send_frame(1, 1, 1, 1);
    drain();

    // back-to-back: frame 2 ends during DIVIDE and is dropped
    fill_img(8'd0); img[1][3] = 8'd255;
    send_frame(3, 1, 1, 0);
    fill_img(8'd0); img[3][6] = 8'd255;
    send_frame(6, 3, 1, 0);
    fill_img(8'd0); img[0][1] = 8'd255; img[2][4] = 8'd255;
    send_frame(2, 1, 1, 0);
    drain();

    // reset mid-divide aborts the result
    fill_img(8'd0); img[2][2] = 8'd200;
    send_frame(2, 2, 1, 0);
    idle(9);
    rst_n = 1'b0;
    exp_q.delete();
    last_done = -1;
    idle(2);
    check("midrst_x", int'(x_out), 0);
    check("midrst_y", int'(y_out), 0);
    check("midrst_found", int'(found_out), 0);
    rst_n = 1'b1;
    idle(40);
    fill_img(8'd0); img[3][7] = 8'd255;
    send_frame(7, 3, 1, 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/y_centroid.md
Y_CENTROID -- requirements
Module: y_centroid

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 Parameter MIN_COUNT, default 16, minimum bright-pixel count for a valid centroid.
REQ-004 clk_in  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  pixel qualifier; y_in, hcount_in and vcount_in are sampled only when high.
REQ-007 y_in  input  8  luminance from the upstream rgb_to_y stage, already aligned with hcount_in and vcount_in.
REQ-008 hcount_in  input  11  pixel column, 0..H_ACTIVE-1.
REQ-009 vcount_in  input  10  pixel row, 0..V_ACTIVE-1.
REQ-010 threshold_in  input  8  brightness threshold, sampled with each valid pixel.
REQ-011 x_out  output  11  centroid column.
REQ-012 y_out  output  10  centroid row.
REQ-013 found_out  output  1  high when the reported centroid is meaningful.
REQ-014 valid_out  output  1  one-cycle pulse marking a new x_out, y_out and found_out result.

Function
REQ-015 Bright pixel: valid_in=1 and y_in >= threshold_in (unsigned; equality counts).
REQ-016 Per bright pixel, accumulators SHALL update: count += 1 (20 bit), sum_x += hcount_in (32 bit), sum_y += vcount_in (32 bit).
REQ-017 Frame end: valid_in=1 with hcount_in=H_ACTIVE-1 and vcount_in=V_ACTIVE-1; that pixel SHALL be included in the frame's sums.
REQ-018 At frame end, count, sum_x and sum_y SHALL be snapshotted into divider registers, and the accumulators cleared on the same edge, so the next frame's pixels from the following cycle are accumulated with no gap.
REQ-019 FSM states: IDLE, DIVIDE, DONE.
  - IDLE -> DIVIDE at frame end when snapshot count >= MIN_COUNT.
  - IDLE -> DONE at frame end when snapshot count < MIN_COUNT.
  - DIVIDE -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally after one cycle.
REQ-020 DIVIDE SHALL run two parallel restoring dividers, sum_x/count and sum_y/count, one quotient bit per cycle, 32 cycles, floor result.
REQ-021 Quotients SHALL be truncated to 11 bits (x) and 10 bits (y); the mean is always below H_ACTIVE/V_ACTIVE, so no saturation is needed.
REQ-022 Latency, with frame end accepted in cycle N:
  - count >= MIN_COUNT: valid_out=1 in cycle N+33, found_out=1, x_out/y_out = quotients.
  - count < MIN_COUNT: valid_out=1 in cycle N+1, found_out=0, x_out=0, y_out=0.
REQ-023 x_out, y_out and found_out SHALL hold their values until the next valid_out pulse.
REQ-024 Frame end while in DIVIDE or DONE: that frame's sums SHALL be discarded (accumulators still cleared), the in-flight division SHALL complete unaffected, and no extra valid_out is produced.
REQ-025 Accumulation SHALL continue during DIVIDE and DONE.
REQ-026 Pixels with hcount_in >= H_ACTIVE or vcount_in >= V_ACTIVE SHALL be ignored.

Reset
REQ-027 While rst_n_in=0: state=IDLE; all accumulators and divider registers 0; x_out=0, y_out=0, found_out=0, valid_out=0.
REQ-028 Reset asserted mid-DIVIDE SHALL abort the division with no valid_out; the first full frame after release SHALL produce a correct result.

Verification (H_ACTIVE=8, V_ACTIVE=4, MIN_COUNT=1, threshold_in=128, valid_in=1 continuously unless stated)
REQ-029 Single pixel y=200 at (5,2), all others 0 -> valid_out at N+33, x_out=5, y_out=2, found_out=1.
REQ-030 Pixels y=255 at (2,1) and (5,3) -> x_out=3 (7/2 floor), y_out=2, found_out=1.
REQ-031 All pixels y=127 -> valid_out at N+1, found_out=0, x_out=0, y_out=0; pixel y=128 at (0,0) in the next frame -> found_out=1, x_out=0, y_out=0.
REQ-032 Back-to-back frames with no blanking (second frame end at N+32, during DIVIDE) -> exactly one valid_out carrying frame-1 result; frame 2 discarded; frame 3 reported correctly.
REQ-033 rst_n_in low for 2 cycles at N+10 -> no valid_out, outputs 0; next frame with pixel at (7,3) -> x_out=7, y_out=3.
REQ-034 Pixel with hcount_in=9 and y_in=255 -> ignored; count unchanged.
